mem_host_ctrl: RTL
==================

Name: mem_host_ctrl

Overview:
- Initiator-side controller for the FSM-based single-port memory (read/write strobes, 4-bit addr, 8-bit data, ready completion).
- Accepts one command at a time from a valid/ready user port and converts it to a one-cycle mem_read/mem_write strobe.
- Waits for mem_ready, then returns read data or a write acknowledge on a valid/ready response port.
- Includes a per-transaction timeout and a saturating timeout counter for debug.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, memory data width
TIMEOUT, 16, max cycles spent in WAIT before aborting with error (>=2)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  user command present
cmd_ready  out  1  controller can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  user accepts response
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  transaction timed out
mem_read  out  1  read strobe to memory
mem_write  out  1  write strobe to memory
mem_addr  out  ADDR_W  address to memory
mem_din  out  DATA_W  write data to memory
mem_dout  in  DATA_W  read data from memory
mem_ready  in  1  memory completion strobe
timeout_cnt  out  8  saturating count of timed-out transactions

Behaviour:
- Reset:
  - reset low forces state IDLE immediately (async).
  - All outputs reset to 0 except cmd_ready, which is 1.
  - timeout_cnt and the WAIT timer clear.
  - Reset mid-transaction aborts it; no response is produced. An in-flight strobe drops at once.
- All outputs are registered. mem_read and mem_write are never 1 together.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready (cycle T):
    - Latch cmd_write/cmd_addr/cmd_wdata into mem_addr/mem_din.
    - Go to ISSUE; cmd_ready=0 from T+1.
  - ISSUE (exactly 1 cycle, T+1): mem_write=1 if write, else mem_read=1. Clear timer; go to WAIT.
  - WAIT:
    - Strobes are 0; mem_addr/mem_din stay stable.
    - If mem_ready=1:
      - Read: capture mem_dout into rsp_rdata. Write: rsp_rdata=0.
      - Set rsp_err=0 and go to RESP.
    - Else the timer increments. When the timer reaches TIMEOUT-1 with mem_ready still 0:
      - Set rsp_err=1, rsp_rdata=0, timeout_cnt+=1 (saturating at 255), and go to RESP.
    - mem_ready is sampled only in WAIT. Highs seen in IDLE/ISSUE/RESP are ignored.
  - RESP: rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1. Then go to IDLE: rsp_valid=0 and cmd_ready=1 next cycle.
- Latency: command accepted at T, strobe at T+1, earliest mem_ready sample at T+2, rsp_valid at T+3.
- Back-to-back: a new command can be accepted no earlier than 1 cycle after the response handshake.
- mem_ready arriving on the same cycle the timer expires counts as success: mem_ready has priority over timeout.
- cmd_valid while cmd_ready=0 is held off. Command fields are sampled only at the handshake, so changes while waiting are harmless.
- Address/data widths pass straight through; there is no wrap or arithmetic on the address.

Test Plan:
- Write then read: write 0x0→A5, 0x1→5A, 0x2→FF, 0x3→12, 0x4→00, then read 0x0–0x4. Expect:
  - rsp_rdata = A5, 5A, FF, 12, 00 in that order, with rsp_err=0 throughout.
  - Each strobe exactly 1 cycle high.
- Latency: memory model asserts mem_ready the cycle after the strobe → rsp_valid exactly 3 cycles after the cmd handshake. A 5-cycle-delay model → rsp_valid at T+7.
- Backpressure: hold rsp_ready=0 for 4 cycles on a read of 0x2 → rsp_valid and rsp_rdata=FF held stable, cmd_ready=0 throughout. Release → cmd_ready=1 next cycle.
- Timeout: model never asserts mem_ready → rsp_err=1 and rsp_rdata=00 after 16 WAIT cycles, timeout_cnt=1. Repeat 300 times → timeout_cnt saturates at 255.
- Priority edge: mem_ready asserted on the final WAIT cycle → rsp_err=0 with valid data, and timeout_cnt unchanged.
- Reset mid-op: drop reset during WAIT of a read → all outputs return to reset values immediately with no rsp_valid. After release, a read of 0x1 returns 5A.

Source files
------------

// File: rtl/mem_host_ctrl.sv
// Initiator-side controller: turns valid/ready commands into single-cycle memory
// strobes, waits for mem_ready (with timeout) and returns a valid/ready response.
module mem_host_ctrl #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic [7:0]        timeout_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              wr_q, wr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            wr_q        <= 1'b0;
            tmr_q       <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            wr_q        <= wr_d;
            tmr_q       <= tmr_d;
            tcnt_q      <= tcnt_d;
        end
    end

    // Next-state and next-output logic; strobes default low so they last one cycle
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        wr_d        = wr_q;
        tmr_d       = tmr_q;
        tcnt_d      = tcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = S_ISSUE;
                    cmd_ready_d = 1'b0;
                    wr_d        = cmd_write;
                    mem_addr_d  = cmd_addr;
                    mem_din_d   = cmd_wdata;
                    mem_write_d = cmd_write;
                    mem_read_d  = !cmd_write;
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // mem_ready wins over a timer expiring in the same cycle
                if (mem_ready) begin
                    rsp_rdata_d = wr_q ? '0 : mem_dout;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (tmr_q == TMR_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (tcnt_q != CNT_MAX) begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                    state_d = S_RESP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign timeout_cnt = tcnt_q;

endmodule
